// File: rtl/extend_and_stream.sv
// Per-lane enable gating (zero / hold / ones) into a registered skid-buffered
// output stream, with a saturating count of words that had any lane gated.
module extend_and_stream #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH-1:0]       en,
    input  logic [1:0]          mode,
    output logic [CH*WIDTH-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         gate_cnt,
    input  logic                cnt_clr
);

    localparam logic [1:0] MODE_HOLD = 2'b01;
    localparam logic [1:0] MODE_ONES = 2'b10;

    logic [CH-1:0][WIDTH-1:0] last_q;
    logic [CH-1:0][WIDTH-1:0] last_d;
    logic [CH*WIDTH-1:0]      gated;
    logic [CH*WIDTH-1:0]      main_q, main_d;
    logic [CH*WIDTH-1:0]      skid_q, skid_d;
    logic                     main_valid_q, main_valid_d;
    logic                     skid_valid_q, skid_valid_d;
    logic                     rdy_q;
    logic [15:0]              cnt_q, cnt_d;
    logic                     accept;
    logic                     main_free;

    assign accept    = in_valid && rdy_q;
    assign main_free = !main_valid_q || out_ready;

    always_comb begin
        gated  = '0;
        last_d = last_q;
        for (int c = 0; c < CH; c++) begin
            if (en[c]) begin
                gated[c*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
                if (accept) last_d[c] = in_data[c*WIDTH +: WIDTH];
            end else begin
                unique case (mode)
                    MODE_HOLD: gated[c*WIDTH +: WIDTH] = last_q[c];
                    MODE_ONES: gated[c*WIDTH +: WIDTH] = '1;
                    default:   gated[c*WIDTH +: WIDTH] = '0;
                endcase
            end
        end
    end

    // A full skid implies in_ready is low, so draining skid never races an accept.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q && out_ready) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (main_free) begin
                main_d       = gated;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = gated;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && (en != '1) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q       <= '0;
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            last_q       <= last_d;
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= !skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = main_valid_q;
    assign gate_cnt  = cnt_q;

endmodule

// File: tb/tb_extend_and_stream.sv
// Directed bench for extend_and_stream: gating modes, skid backpressure,
// counter saturation/clear and asynchronous reset.
module tb_extend_and_stream;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  en;
    logic [1:0]  mode;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] gate_cnt;
    logic        cnt_clr;

    int total = 0;
    int bad   = 0;

    extend_and_stream #(.WIDTH(8), .CH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gate_cnt  (gate_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] e,
                        input logic [1:0] m);
        in_data  = d;
        en       = e;
        mode     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        en        = 4'hF;
        mode      = 2'b00;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_gate_cnt", {16'd0, gate_cnt}, 32'd0);
        RST = 1'b0;
        #1;
        chk("rdy_before_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rdy_after_edge", {31'd0, in_ready}, 32'd1);

        // pass-through stream
        in_valid = 1'b1;
        in_data  = 32'h04030201;
        tick();
        chk("pass_w0", out_data, 32'h04030201);
        chk("pass_v0", {31'd0, out_valid}, 32'd1);
        in_data = 32'h08070605;
        tick();
        chk("pass_w1", out_data, 32'h08070605);
        chk("pass_v1", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("pass_idle", {31'd0, out_valid}, 32'd0);
        chk("pass_cnt", {16'd0, gate_cnt}, 32'd0);

        send(32'hDDCCBBAA, 4'b0101, 2'b00);
        chk("zero_data", out_data, 32'h00CC00AA);
        chk("zero_cnt", {16'd0, gate_cnt}, 32'd1);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_idle", {16'd0, gate_cnt}, 32'd0);

        send(32'h44332211, 4'hF, 2'b00);
        chk("hold_seed", out_data, 32'h44332211);
        send(32'hFFFFFFFF, 4'b0010, 2'b01);
        chk("hold_one", out_data, 32'h4433FF11);
        send(32'h00000000, 4'b0000, 2'b01);
        chk("hold_none", out_data, 32'h4433FF11);
        chk("hold_cnt", {16'd0, gate_cnt}, 32'd2);

        send(32'h12345678, 4'b1000, 2'b10);
        chk("ones_data", out_data, 32'h12FFFFFF);
        send(32'h12345678, 4'b1000, 2'b11);
        chk("mode3_data", out_data, 32'h12000000);
        chk("mode3_cnt", {16'd0, gate_cnt}, 32'd4);
        tick();

        // backpressure: out_ready low across three edges
        en        = 4'hF;
        mode      = 2'b00;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1A2A3A4;
        tick();
        chk("bp_main_a", out_data, 32'hA1A2A3A4);
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        in_data = 32'hB1B2B3B4;
        tick();
        chk("bp_rdy_drop", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", out_data, 32'hA1A2A3A4);
        in_data = 32'hC1C2C3C4;
        tick();
        chk("bp_still_a", out_data, 32'hA1A2A3A4);
        chk("bp_still_v", {31'd0, out_valid}, 32'd1);
        chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", out_data, 32'hB1B2B3B4);
        chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out_c", out_data, 32'hC1C2C3C4);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // counter saturation
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        en       = 4'h0;
        in_data  = 32'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("cnt_fffe", {16'd0, gate_cnt}, 32'h0000FFFE);
        tick();
        chk("cnt_ffff", {16'd0, gate_cnt}, 32'h0000FFFF);
        tick();
        chk("cnt_sat", {16'd0, gate_cnt}, 32'h0000FFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", {16'd0, gate_cnt}, 32'd0);
        tick();
        chk("cnt_after_clr", {16'd0, gate_cnt}, 32'd1);

        // asynchronous reset mid-stream
        en      = 4'hF;
        in_data = 32'h55667788;
        tick();
        chk("pre_rst_v", {31'd0, out_valid}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_cnt", {16'd0, gate_cnt}, 32'd0);
        in_valid = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        chk("arst_rdy_hold", {31'd0, in_ready}, 32'd0);
        tick();
        chk("arst_rdy_up", {31'd0, in_ready}, 32'd1);
        send(32'hFFFFFFFF, 4'h0, 2'b01);
        chk("arst_last_zero", out_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
